// File: rtl/sdram_ctrl_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_ctrl_arbiter_if
// Request/return bus of the SDRAM controller protocol, carrying N_LANES
// independent channels side by side (lane i occupies slice i of each vector).
//   wr          byte write strobes, WORD_LEN per lane (any bit set = write)
//   rd          read request, one per lane
//   addr        request address, ADDR_WIDTH per lane
//   write_data  write data, DATA_WIDTH per lane
//   rdy         request accepted this cycle, one per lane
//   rvalid      read return, one per lane
//   error       error qualifier, valid with rvalid
//   read_data   read data, shared by all lanes, qualified by rvalid
// Modports: master issues requests, slave accepts them and returns data.
// ---------------------------------------------------------------------------
interface sdram_ctrl_arbiter_if #(
  parameter int N_LANES    = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_LEN   = DATA_WIDTH / 8
);
  logic [N_LANES*WORD_LEN-1:0]   wr;
  logic [N_LANES-1:0]            rd;
  logic [N_LANES*ADDR_WIDTH-1:0] addr;
  logic [N_LANES*DATA_WIDTH-1:0] write_data;
  logic [N_LANES-1:0]            rdy;
  logic [N_LANES-1:0]            rvalid;
  logic [N_LANES-1:0]            error;
  logic [DATA_WIDTH-1:0]         read_data;

  modport master (
    output wr, rd, addr, write_data,
    input  rdy, rvalid, error, read_data
  );

  modport slave (
    input  wr, rd, addr, write_data,
    output rdy, rvalid, error, read_data
  );
endinterface

// File: rtl/sdram_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_ctrl_arbiter
// Multi-channel front end for the SDRAM controller. N_PORTS manager channels
// are arbitrated round-robin onto the single controller request port. A tag
// FIFO remembers which channel issued each outstanding read so in-order read
// returns are steered back to the right channel.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   m           slave side of an N_PORTS-lane bus from the managers
//   s           master side of a 1-lane bus to the controller
//   orphan_err  sticky flag: a read return arrived with no outstanding tag
//
// Build option: define SDRAM_ARB_PRIO_EN to make channel 0 strict priority
// (it never moves the round-robin pointer; channels 1..N_PORTS-1 rotate among
// themselves whenever channel 0 is idle or ineligible).
// ---------------------------------------------------------------------------
module sdram_ctrl_arbiter #(
  parameter int N_PORTS         = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_LEN        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_ctrl_arbiter_if.slave  m,
  sdram_ctrl_arbiter_if.master s,
  output logic                 orphan_err
);

  localparam int PW = $clog2(N_PORTS);
  localparam int TW = $clog2(MAX_OUTSTANDING);
  localparam logic [TW:0] FULL_COUNT = (TW+1)'(MAX_OUTSTANDING);

  typedef logic [PW-1:0] port_t;

  // State
  port_t         rr_ptr_reg;
  logic [TW-1:0] wr_ptr_reg;
  logic [TW-1:0] rd_ptr_reg;
  logic [TW:0]   count_reg;
  logic          orphan_err_reg;
  port_t         tag_mem [MAX_OUTSTANDING];

  // Per-channel request decode
  logic [N_PORTS-1:0] has_wr;
  logic [N_PORTS-1:0] has_rd;
  logic [N_PORTS-1:0] eligible;
  logic [N_PORTS-1:0] rr_eligible;

  logic  fifo_full;
  logic  fifo_empty;
  logic  gnt_valid;
  port_t gnt_idx;
  logic  xfer;
  logic  push;
  logic  pop;
  port_t head_tag;

  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);

  // A request carrying rd (even combined with wr) needs a tag slot, so it is
  // held off while the FIFO is full; a pop in the same cycle does not help
  // because the full flag comes straight from the registered count.
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_req
      assign has_wr[gi]   = |m.wr[gi*WORD_LEN +: WORD_LEN];
      assign has_rd[gi]   = m.rd[gi];
      assign eligible[gi] = has_rd[gi] ? !fifo_full : has_wr[gi];
`ifdef SDRAM_ARB_PRIO_EN
      // Channel 0 is served outside the rotation.
      assign rr_eligible[gi] = (gi == 0) ? 1'b0 : eligible[gi];
`else
      assign rr_eligible[gi] = eligible[gi];
`endif
    end
  endgenerate

  // Grant: first eligible channel at or after rr_ptr, wrapping.
  always_comb begin : p_grant
    int    sum;
    port_t idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = 0;
    idx       = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sum = int'(rr_ptr_reg) + k;
      if (sum >= N_PORTS) begin
        sum = sum - N_PORTS;
      end
      idx = port_t'(sum);
      if (!gnt_valid && rr_eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
`ifdef SDRAM_ARB_PRIO_EN
    if (eligible[0]) begin
      gnt_valid = 1'b1;
      gnt_idx   = '0;
    end
`endif
  end

  assign xfer = gnt_valid && s.rdy[0];
  assign push = xfer && has_rd[gnt_idx];
  assign pop  = s.rvalid[0] && !fifo_empty;

  // Request mux towards the controller; all zero when nothing is granted.
  always_comb begin
    s.wr         = '0;
    s.rd         = '0;
    s.addr       = '0;
    s.write_data = '0;
    m.rdy        = '0;
    if (gnt_valid) begin
      s.wr         = m.wr[gnt_idx*WORD_LEN +: WORD_LEN];
      s.rd[0]      = m.rd[gnt_idx];
      s.addr       = m.addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      s.write_data = m.write_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      m.rdy[gnt_idx] = s.rdy[0];
    end
  end

  // Return path: the head tag picks the channel. The tag store is a small
  // register array read asynchronously because the return must be routed in
  // the same cycle the controller presents it.
  assign head_tag    = tag_mem[rd_ptr_reg];
  assign m.read_data = s.read_data;

  always_comb begin
    m.rvalid = '0;
    m.error  = '0;
    if (pop) begin
      m.rvalid[head_tag] = 1'b1;
      m.error[head_tag]  = s.error[0];
    end
  end

  // Tag storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      orphan_err_reg <= 1'b0;
    end else begin
      if (xfer) begin
`ifdef SDRAM_ARB_PRIO_EN
        if (gnt_idx != '0) begin
          rr_ptr_reg <= (gnt_idx == port_t'(N_PORTS-1)) ? '0 : gnt_idx + 1'b1;
        end
`else
        rr_ptr_reg <= (gnt_idx == port_t'(N_PORTS-1)) ? '0 : gnt_idx + 1'b1;
`endif
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (s.rvalid[0] && fifo_empty) begin
        orphan_err_reg <= 1'b1;
      end
    end
  end

  assign orphan_err = orphan_err_reg;

endmodule

// File: tb/tb_sdram_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_ctrl_arbiter
// Directed bench for sdram_ctrl_arbiter with a 4-channel, 32-bit setup.
// Stimulus pushes expected grants and read returns into queues; a monitor on
// the falling edge pops and compares whenever the DUT raises m.rdy or
// m.rvalid. A few state checks (reset, stall, orphan flag) are made inline.
// ---------------------------------------------------------------------------
module tb_sdram_ctrl_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WL = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic orphan_err;

  always #5 clk = ~clk;

  // Bench-side drivers
  logic [N*WL-1:0] m_wr;
  logic [N-1:0]    m_rd;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic            s_rdy;
  logic            s_rvalid;
  logic            s_error;
  logic [DW-1:0]   s_rdata;

  sdram_ctrl_arbiter_if #(.N_LANES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();
  sdram_ctrl_arbiter_if #(.N_LANES(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  assign m_bus.wr         = m_wr;
  assign m_bus.rd         = m_rd;
  assign m_bus.addr       = m_addr;
  assign m_bus.write_data = m_wdata;
  assign s_bus.rdy        = s_rdy;
  assign s_bus.rvalid     = s_rvalid;
  assign s_bus.error      = s_error;
  assign s_bus.read_data  = s_rdata;

  sdram_ctrl_arbiter #(
    .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL), .MAX_OUTSTANDING(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m          (m_bus),
    .s          (s_bus),
    .orphan_err (orphan_err)
  );

  typedef struct {
    logic [N-1:0]  rdy;
    logic [WL-1:0] wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct {
    logic [N-1:0]  rv;
    logic [N-1:0]  er;
    logic [DW-1:0] data;
  } ret_t;

  gnt_t gq[$];
  ret_t rq[$];

  int checks = 0;
  int passes = 0;

  localparam logic [DW-1:0] WMASK = 32'hDA7A_0000;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_wr     = '0;
    m_rd     = '0;
    m_addr   = '0;
    m_wdata  = '0;
    s_rvalid = 1'b0;
    s_error  = 1'b0;
    s_rdata  = '0;
  endtask

  task automatic put_wr(int ch, logic [WL-1:0] strb, logic [AW-1:0] a);
    m_wr[ch*WL +: WL]   = strb;
    m_addr[ch*AW +: AW] = a;
    m_wdata[ch*DW +: DW] = a ^ WMASK;
  endtask

  task automatic put_rd(int ch, logic [AW-1:0] a);
    m_rd[ch]             = 1'b1;
    m_addr[ch*AW +: AW]  = a;
    m_wdata[ch*DW +: DW] = a ^ WMASK;
  endtask

  task automatic exp_gnt(int ch, logic [WL-1:0] strb, logic rd, logic [AW-1:0] a);
    gnt_t e;
    e.rdy   = N'(1 << ch);
    e.wr    = strb;
    e.rd    = rd;
    e.addr  = a;
    e.wdata = a ^ WMASK;
    gq.push_back(e);
  endtask

  task automatic ret(int ch, logic err, logic [DW-1:0] d);
    ret_t e;
    e.rv   = N'(1 << ch);
    e.er   = err ? N'(1 << ch) : '0;
    e.data = d;
    rq.push_back(e);
    s_rvalid = 1'b1;
    s_error  = err;
    s_rdata  = d;
  endtask

  // Monitor: compares every presented grant / return against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (|m_bus.rdy) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", 64'(m_bus.rdy), 64'd0);
        end else begin
          gnt_t e;
          e = gq.pop_front();
          check("gnt_rdy",   64'(m_bus.rdy),        64'(e.rdy));
          check("gnt_wr",    64'(s_bus.wr),         64'(e.wr));
          check("gnt_rd",    64'(s_bus.rd),         64'(e.rd));
          check("gnt_addr",  64'(s_bus.addr),       64'(e.addr));
          check("gnt_wdata", 64'(s_bus.write_data), 64'(e.wdata));
          $display("grant: m_rdy=%b s_wr=%h s_rd=%b s_addr=%h", m_bus.rdy, s_bus.wr, s_bus.rd, s_bus.addr);
        end
      end
      if (|m_bus.rvalid) begin
        if (rq.size() == 0) begin
          check("unexpected_return", 64'(m_bus.rvalid), 64'd0);
        end else begin
          ret_t e;
          e = rq.pop_front();
          check("ret_rvalid", 64'(m_bus.rvalid),    64'(e.rv));
          check("ret_error",  64'(m_bus.error),     64'(e.er));
          check("ret_data",   64'(m_bus.read_data), 64'(e.data));
          $display("return: m_rvalid=%b m_error=%b data=%h", m_bus.rvalid, m_bus.error, m_bus.read_data);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    s_rdy = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset / idle state
    @(negedge clk);
    check("rst_m_rdy",      64'(m_bus.rdy),    64'd0);
    check("rst_m_rvalid",   64'(m_bus.rvalid), 64'd0);
    check("rst_m_error",    64'(m_bus.error),  64'd0);
    check("rst_s_wr",       64'(s_bus.wr),     64'd0);
    check("rst_s_rd",       64'(s_bus.rd),     64'd0);
    check("rst_s_addr",     64'(s_bus.addr),   64'd0);
    check("rst_orphan_err", 64'(orphan_err),   64'd0);
    step();

    // Single write on ch2 -> rr_ptr becomes 3
    s_rdy = 1'b1;
    put_wr(2, 4'hF, 32'h100);
    exp_gnt(2, 4'hF, 1'b0, 32'h100);
    step();
    idle_inputs();

    // All channels writing continuously: rotation starts at ch3
    for (int k = 0; k < 8; k++) begin
`ifdef SDRAM_ARB_PRIO_EN
      exp_gnt(0, 4'hF, 1'b0, 32'h200);
`else
      exp_gnt((3 + k) % N, 4'hF, 1'b0, 32'(32'h200 + ((3 + k) % N) * 4));
`endif
    end
    for (int c = 0; c < N; c++) put_wr(c, 4'hF, 32'(32'h200 + c * 4));
    repeat (8) step();
    idle_inputs();

    // Reads ch1, ch3, ch0 back to back, then in-order returns
    put_rd(1, 32'h300); exp_gnt(1, 4'h0, 1'b1, 32'h300); step(); idle_inputs();
    put_rd(3, 32'h304); exp_gnt(3, 4'h0, 1'b1, 32'h304); step(); idle_inputs();
    put_rd(0, 32'h308); exp_gnt(0, 4'h0, 1'b1, 32'h308); step(); idle_inputs();
    ret(1, 1'b0, 32'hA); step();
    ret(3, 1'b1, 32'hB); step();
    ret(0, 1'b0, 32'hC); step();
    idle_inputs();

    // Fill the tag FIFO: owners 3,0,1,3
    put_rd(3, 32'h400); exp_gnt(3, 4'h0, 1'b1, 32'h400); step(); idle_inputs();
    put_rd(0, 32'h404); exp_gnt(0, 4'h0, 1'b1, 32'h404); step(); idle_inputs();
    put_rd(1, 32'h408); exp_gnt(1, 4'h0, 1'b1, 32'h408); step(); idle_inputs();
    put_rd(3, 32'h40C); exp_gnt(3, 4'h0, 1'b1, 32'h40C); step(); idle_inputs();

    // Full: ch1 write wins, ch2 read waits
    put_rd(2, 32'h500);
    put_wr(1, 4'h3, 32'h600);
    exp_gnt(1, 4'h3, 1'b0, 32'h600);
    step();
    m_wr = '0;
    // Pop this cycle must not unblock ch2 yet
    ret(3, 1'b0, 32'h11);
    @(negedge clk);
    check("stall_m_rdy", 64'(m_bus.rdy), 64'd0);
    step();
    s_rvalid = 1'b0;
    exp_gnt(2, 4'h0, 1'b1, 32'h500);
    step();
    idle_inputs();

    // Drain owners 0,1,3,2; error on the second
    ret(0, 1'b0, 32'h21); step();
    ret(1, 1'b1, 32'h22); step();
    ret(3, 1'b0, 32'h23); step();
    ret(2, 1'b0, 32'h24); step();
    idle_inputs();

    // Orphan return
    s_rvalid = 1'b1;
    s_rdata  = 32'h99;
    @(negedge clk);
    check("orphan_no_rvalid", 64'(m_bus.rvalid), 64'd0);
    check("orphan_err_pre",   64'(orphan_err),   64'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("orphan_err_set", 64'(orphan_err), 64'd1);
    repeat (3) step();
    @(negedge clk);
    check("orphan_err_held", 64'(orphan_err), 64'd1);
    step();

    // Three reads outstanding (first carries a write too), then reset
    put_wr(0, 4'hF, 32'h700); put_rd(0, 32'h700);
    exp_gnt(0, 4'hF, 1'b1, 32'h700); step(); idle_inputs();
    put_rd(1, 32'h704); exp_gnt(1, 4'h0, 1'b1, 32'h704); step(); idle_inputs();
    put_rd(2, 32'h708); exp_gnt(2, 4'h0, 1'b1, 32'h708); step(); idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst2_orphan_err", 64'(orphan_err),   64'd0);
    check("rst2_m_rdy",      64'(m_bus.rdy),    64'd0);
    check("rst2_m_rvalid",   64'(m_bus.rvalid), 64'd0);
    step();

    // rr_ptr back at 0: all four writing -> ch0
    for (int c = 0; c < N; c++) put_wr(c, 4'hF, 32'(32'h900 + c * 4));
    exp_gnt(0, 4'hF, 1'b0, 32'h900);
    step();
    idle_inputs();

    // Fresh read routed with no stale tag
    put_rd(3, 32'hA00); exp_gnt(3, 4'h0, 1'b1, 32'hA00); step(); idle_inputs();
    ret(3, 1'b0, 32'h55); step();
    idle_inputs();
    step();

    @(negedge clk);
    check("gnt_queue_empty", 64'(gq.size()), 64'd0);
    check("ret_queue_empty", 64'(rq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
